sprite_line_scanner: RTL
========================

// Module: sprite_line_scanner
// PURPOSE
//  Scanline sprite evaluator, successor to the per-sprite hit/tile-address unit.
//  Scans attribute memory (OAM) for sprites that intersect the next display line.
//  Runs once per line, kicked in hblank. Fills a SLOTS-deep table of hit sprites,
//  each with its flip-corrected row, for the pixel pipeline; flags per-line overflow.
// PARAMETERS
//  NUM_SPRITES  128  OAM entries scanned, index 0 first (0 = highest priority)
//  OAM_AW       7    OAM address width, clog2(NUM_SPRITES)
//  SLOTS        8    max sprites latched per line
//  SLOT_AW      3    slot index width, clog2(SLOTS)
//  COORD_W      11   screen coordinate width
// PORTS
//  vga_clk      in   1         sole clock, rising edge
//  reset        in   1         asynchronous, active-high
//  start        in   1         1-cycle pulse: begin scan for line
//  line         in   COORD_W   target line y, sampled when start accepted
//  oam_req      out  1         read request, held until oam_ack
//  oam_addr     out  OAM_AW    entry being read, stable while oam_req
//  oam_ack      in   1         attr0/attr1 valid this cycle
//  oam_attr0    in   32        y=[21:11] rotscale=[22] dbl/disable=[23] shape=[28:27]
//  oam_attr1    in   32        flipy=[1] size=[3:2]
//  slot_rd_idx  in   SLOT_AW   table read index
//  slot_attr0   out  32        registered read, 1-cycle latency
//  slot_attr1   out  32        registered read, 1-cycle latency
//  slot_row     out  6         row within sprite (flip applied), 1-cycle latency
//  slot_count   out  SLOT_AW+1 valid slots, 0..SLOTS
//  busy         out  1         high in SCAN
//  done         out  1         1-cycle pulse at scan end
//  overflow     out  1         >SLOTS hits on this line; sticky until next start
// BEHAVIOUR
//  Reset: state IDLE; oam_req/busy/done/overflow=0, oam_addr=0, slot_count=0,
//   slot_* outputs=0. Reset mid-scan aborts at once; no further OAM reads.
//  FSM IDLE->SCAN on start (cycle N: latch line, clear count/overflow, addr=0,
//   oam_req=1 from N+1). start while busy or in DONE is ignored.
//  SCAN: one request outstanding. On oam_ack evaluate entry:
//   en  = attr0[22] | ~attr0[23]
//   h   = height LUT on {shape,size}: shape0 8/16/32/64; shape1 16/32/32/64;
//         shape2 8/8/16/32; shape3 8 for all sizes
//   oy  = (line - attr0[21:11]) mod 2^COORD_W; hit = en & (oy < h); the
//         unsigned wrap rejects sprites below the line
//   row = flipy ? h-1-oy : oy, low 6 bits
//  Hit with count<SLOTS: write slot[count]={attr0,attr1,row}; count++.
//  Hit with count==SLOTS: overflow=1, scan ends early -> DONE.
//  After ack of addr NUM_SPRITES-1 -> DONE, else addr++ and re-request next cycle.
//  DONE: done=1 for exactly one cycle, then IDLE. oam_req low in IDLE/DONE.
//  Table stable from done until next accepted start. Reads during SCAN return
//   contents as of previous cycle. Entries >= slot_count are don't-care.
//  oam_ack without oam_req is ignored.
// CONFIGURATION
//  SPRITE_DOUBLE_EN defined: attr0[22]&attr0[23] doubles effective height
//   (hit = oy < 2h); row = (flipy ? 2h-1-oy : oy)>>1.
//  SPRITE_DOUBLE_EN undefined: bit 23 with rotscale is ignored; height = h.
// STRUCTURE
//  sprite_pkg: attr field bit positions, scan state enum, height LUT function,
//   SLOT entry struct {attr0,attr1,row}.
//  Sub-module sprite_size_lut: {shape,size} -> width/height; combinational,
//   shared with the pixel pipeline.
// TESTING
//  1: line=20; sprite0 y=16 8x8, rest disabled (attr0[23]=1, [22]=0) -> count=1,
//     slot0 row=4, done after 128 acks, overflow=0.
//  2: flipy 16x16 at y=10, line=12 -> row=13; line=26 -> no hit.
//  3: y=2040 8x8, line=3 -> oy wraps to 11 -> no hit; y=2044 -> hit, row=7.
//  4: 10 hitting sprites idx 0..9, SLOTS=8 -> count=8, slots = idx 0..7,
//     overflow=1, scan ends at addr 8.
//  5: ack delayed 3 cycles each; start re-pulsed mid-scan -> ignored, oam_addr
//     stable while req; reset mid-scan -> req=0 same cycle, count=0.
//  6: SPRITE_DOUBLE_EN, 8x8 rotscale+double at y=0, line=13 -> hit, row=6;
//     without macro -> no hit.

Source files
------------

// File: rtl/sprite_line_scanner_pkg.sv
// Shared types and constants for the scanline sprite evaluator: OAM attribute
// field positions, scan FSM states, slot table entry and the sprite height LUT.
package sprite_line_scanner_pkg;

    localparam int NUM_SPRITES = 128;
    localparam int OAM_AW      = 7;
    localparam int SLOTS       = 8;
    localparam int SLOT_AW     = 3;
    localparam int COORD_W     = 11;

    localparam int A0_Y_LO     = 11;
    localparam int A0_Y_HI     = 21;
    localparam int A0_ROTSCALE = 22;
    localparam int A0_DBL      = 23;
    localparam int A0_SHAPE_LO = 27;
    localparam int A0_SHAPE_HI = 28;
    localparam int A1_FLIPY    = 1;
    localparam int A1_SIZE_LO  = 2;
    localparam int A1_SIZE_HI  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [31:0] attr0;
        logic [31:0] attr1;
        logic [5:0]  row;
    } slot_entry_t;

    // Height in pixels for a {shape,size} pair; shape 3 is the reserved code.
    function automatic logic [6:0] sprite_height(input logic [1:0] shape, input logic [1:0] size);
        logic [6:0] h;
        h = 7'd8;
        case (shape)
            2'd0: begin
                case (size)
                    2'd0:    h = 7'd8;
                    2'd1:    h = 7'd16;
                    2'd2:    h = 7'd32;
                    default: h = 7'd64;
                endcase
            end
            2'd1: begin
                case (size)
                    2'd0:    h = 7'd16;
                    2'd1:    h = 7'd32;
                    2'd2:    h = 7'd32;
                    default: h = 7'd64;
                endcase
            end
            2'd2: begin
                case (size)
                    2'd0:    h = 7'd8;
                    2'd1:    h = 7'd8;
                    2'd2:    h = 7'd16;
                    default: h = 7'd32;
                endcase
            end
            default: h = 7'd8;
        endcase
        return h;
    endfunction

endpackage

// File: rtl/sprite_line_scanner_if.sv
// OAM read port between the scanner (master) and attribute memory (slave).
interface sprite_line_scanner_if import sprite_line_scanner_pkg::*; #(
    parameter int AW = OAM_AW
) ();
    // req rises with a stable addr and stays high until the cycle ack is seen;
    // attr0/attr1 are valid only in that ack cycle. ack without req is ignored.
    logic          req;
    logic [AW-1:0] addr;
    logic          ack;
    logic [31:0]   attr0;
    logic [31:0]   attr1;

    modport master (output req, addr, input ack, attr0, attr1);
    modport slave  (input req, addr, output ack, attr0, attr1);
endinterface

// File: rtl/sprite_line_scanner_size_lut.sv
// Combinational {shape,size} -> sprite height lookup, shared with the pixel pipeline.
module sprite_size_lut import sprite_line_scanner_pkg::*; (
    input  logic [1:0] i_shape,
    input  logic [1:0] i_size,
    output logic [6:0] o_height
);
    assign o_height = sprite_height(i_shape, i_size);
endmodule

// File: rtl/sprite_line_scanner.sv
// Per-line OAM scanner: fills a SLOTS-deep table of sprites hitting the next line.
// Optional macro SPRITE_DOUBLE_EN enables double-size rotscale sprites.
module sprite_line_scanner import sprite_line_scanner_pkg::*; (
    input  logic                 vga_clk,
    input  logic                 reset,
    sprite_line_scanner_if.master oam,
    input  logic                 start,
    input  logic [COORD_W-1:0]   line,
    input  logic [SLOT_AW-1:0]   slot_rd_idx,
    output logic [31:0]          slot_attr0,
    output logic [31:0]          slot_attr1,
    output logic [5:0]           slot_row,
    output logic [SLOT_AW:0]     slot_count,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output scan_state_t          dbg_state
);
    localparam logic [OAM_AW-1:0]  LAST_ADDR  = OAM_AW'(NUM_SPRITES - 1);
    localparam logic [SLOT_AW:0]   FULL_COUNT = (SLOT_AW + 1)'(SLOTS);

    scan_state_t          r_state, w_next_state;
    logic [COORD_W-1:0]   r_line;
    logic [OAM_AW-1:0]    r_addr;
    logic [SLOT_AW:0]     r_count;
    logic                 r_overflow;
    slot_entry_t          r_slots [SLOTS];
    slot_entry_t          r_rd;

    logic                 w_req, w_busy, w_done;
    logic                 w_accept, w_take, w_full;
    logic [6:0]           w_height;
    logic [7:0]           w_eff_h;
    logic                 w_en, w_dbl, w_hit, w_flipy;
    logic [COORD_W-1:0]   w_oy;
    logic [6:0]           w_row_full;
    logic [5:0]           w_row;

    sprite_size_lut u_size_lut (
        .i_shape  (oam.attr0[A0_SHAPE_HI:A0_SHAPE_LO]),
        .i_size   (oam.attr1[A1_SIZE_HI:A1_SIZE_LO]),
        .o_height (w_height)
    );

    // Entry evaluation; the unsigned wrap of oy rejects sprites starting below the line.
    assign w_en    = oam.attr0[A0_ROTSCALE] | ~oam.attr0[A0_DBL];
    assign w_flipy = oam.attr1[A1_FLIPY];
    assign w_oy    = r_line - oam.attr0[A0_Y_HI:A0_Y_LO];
`ifdef SPRITE_DOUBLE_EN
    assign w_dbl   = oam.attr0[A0_ROTSCALE] & oam.attr0[A0_DBL];
`else
    assign w_dbl   = 1'b0;
`endif
    assign w_eff_h    = w_dbl ? {w_height, 1'b0} : {1'b0, w_height};
    assign w_hit      = w_en & (w_oy < {3'b000, w_eff_h});
    // Only meaningful on a hit, where oy < eff_h <= 128 fits in 7 bits.
    assign w_row_full = w_flipy ? (w_eff_h[6:0] - 7'd1 - w_oy[6:0]) : w_oy[6:0];
    assign w_row      = w_dbl ? w_row_full[6:1] : w_row_full[5:0];

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_take   = (r_state == ST_SCAN) && oam.ack;
    assign w_full   = (r_count == FULL_COUNT);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_SCAN;
            ST_SCAN: begin
                if (oam.ack) begin
                    if (w_hit && w_full)          w_next_state = ST_DONE;
                    else if (r_addr == LAST_ADDR) w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_req  = 1'b0;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            ST_SCAN: begin
                w_req  = 1'b1;
                w_busy = 1'b1;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            r_line     <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_accept) begin
            r_line     <= line;
            r_addr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (w_take) begin
            if (w_hit && w_full) r_overflow <= 1'b1;
            else if (w_hit)      r_count    <= r_count + 1'b1;
            if (!(w_hit && w_full) && (r_addr != LAST_ADDR)) r_addr <= r_addr + 1'b1;
        end
    end

    // Table storage needs no reset: entries at or above slot_count are don't-care.
    always_ff @(posedge vga_clk) begin
        if (w_take && w_hit && !w_full) begin
            r_slots[r_count[SLOT_AW-1:0]] <= '{attr0: oam.attr0, attr1: oam.attr1, row: w_row};
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) r_rd <= '0;
        else       r_rd <= r_slots[slot_rd_idx];
    end

    assign oam.req    = w_req;
    assign oam.addr   = r_addr;
    assign busy       = w_busy;
    assign done       = w_done;
    assign overflow   = r_overflow;
    assign slot_count = r_count;
    assign slot_attr0 = r_rd.attr0;
    assign slot_attr1 = r_rd.attr1;
    assign slot_row   = r_rd.row;
    assign dbg_state  = r_state;

endmodule
